// File: rtl/vga_timing_rx.sv
// VGA timing receiver: measures hsync/vsync timing against the expected raster, locks after
// a run of clean frames and regenerates pixel coordinates and data-enable while locked.
module vga_timing_rx #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_VIS_START = 142,
  parameter int H_VISIBLE   = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_VIS_START = 34,
  parameter int V_VISIBLE   = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic       locked,
  output logic       de,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic       frame_start,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       err
);

  localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
  localparam logic [10:0] H_SYNC_C  = 11'(H_SYNC);
  localparam logic [10:0] H_VS_C    = 11'(H_VIS_START);
  localparam logic [10:0] H_VE_C    = 11'(H_VIS_START + H_VISIBLE);
  localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [10:0] V_VS_C    = 11'(V_VIS_START);
  localparam logic [10:0] V_VE_C    = 11'(V_VIS_START + V_VISIBLE);
  localparam logic [3:0]  LOCK_C    = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3ff) ? v : v + 10'd1;
  endfunction

  state_t     state_q, state_d;
  logic       hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [9:0] rx_h_q, rx_h_d, rx_v_q, rx_v_d, hs_low_q, hs_low_d;
  logic       vs_pend_q, vs_pend_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic       locked_q, locked_d, de_q, de_d, frame_start_q, frame_start_d, err_q, err_d;
  logic [9:0] px_x_q, px_x_d, px_y_q, px_y_d, line_len_q, line_len_d;
  logic [9:0] frame_lines_q, frame_lines_d;

  logic hfall, hrise, vfall, boundary, bad_line, bad_frame, h_vis, v_vis;

  always_comb begin
    hfall     = hs_prev_q & ~hsync_in;
    hrise     = ~hs_prev_q & hsync_in;
    vfall     = vs_prev_q & ~vsync_in;
    boundary  = hfall & vs_pend_q;
    bad_line  = (hfall && ({1'b0, rx_h_q} + 11'd1 != H_TOTAL_C))
             || (hrise && ({1'b0, hs_low_q} != H_SYNC_C))
             || (rx_h_q == 10'h3ff);
    bad_frame = boundary && ({1'b0, rx_v_q} + 11'd1 != V_TOTAL_C);

    hs_prev_d = hsync_in;
    vs_prev_d = vsync_in;
    rx_h_d     = hfall ? 10'd0 : sat_inc(rx_h_q);
    line_len_d = hfall ? sat_inc(rx_h_q) : line_len_q;
    // The hfall cycle is itself the first low sample, so the count restarts at 1.
    hs_low_d   = hfall ? 10'd1 : (!hsync_in ? sat_inc(hs_low_q) : hs_low_q);
    vs_pend_d  = vfall ? 1'b1 : (boundary ? 1'b0 : vs_pend_q);
    rx_v_d        = boundary ? 10'd0 : (hfall ? sat_inc(rx_v_q) : rx_v_q);
    frame_lines_d = boundary ? sat_inc(rx_v_q) : frame_lines_q;
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_d      = 1'b0;
    case (state_q)
      SEARCH: begin
        if (boundary) begin
          state_d    = VERIFY;
          good_cnt_d = 4'd0;
        end
      end
      VERIFY: begin
        if (bad_line || bad_frame) begin
          state_d    = SEARCH;
          good_cnt_d = 4'd0;
        end else if (boundary) begin
          good_cnt_d = good_cnt_q + 4'd1;
          if (good_cnt_q + 4'd1 >= LOCK_C) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (bad_line || bad_frame) begin
          state_d    = SEARCH;
          good_cnt_d = 4'd0;
          err_d      = 1'b1;
        end
      end
      default: begin
        state_d    = SEARCH;
        good_cnt_d = 4'd0;
      end
    endcase
  end

  // Output stage: describes the rx_h/rx_v state of the current cycle, one cycle later.
  always_comb begin
    h_vis    = ({1'b0, rx_h_q} >= H_VS_C) && ({1'b0, rx_h_q} < H_VE_C);
    v_vis    = ({1'b0, rx_v_q} >= V_VS_C) && ({1'b0, rx_v_q} < V_VE_C);
    locked_d = (state_d == LOCKED);
    de_d     = locked_d & h_vis & v_vis;
    px_x_d   = de_d ? rx_h_q - H_VS_C[9:0] : 10'd0;
    px_y_d   = de_d ? rx_v_q - V_VS_C[9:0] : 10'd0;
    frame_start_d = de_d && (px_x_d == 10'd0) && (px_y_d == 10'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SEARCH;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      rx_h_q        <= '0;
      rx_v_q        <= '0;
      hs_low_q      <= '0;
      vs_pend_q     <= 1'b0;
      good_cnt_q    <= '0;
      locked_q      <= 1'b0;
      de_q          <= 1'b0;
      px_x_q        <= '0;
      px_y_q        <= '0;
      frame_start_q <= 1'b0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      rx_h_q        <= rx_h_d;
      rx_v_q        <= rx_v_d;
      hs_low_q      <= hs_low_d;
      vs_pend_q     <= vs_pend_d;
      good_cnt_q    <= good_cnt_d;
      locked_q      <= locked_d;
      de_q          <= de_d;
      px_x_q        <= px_x_d;
      px_y_q        <= px_y_d;
      frame_start_q <= frame_start_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      err_q         <= err_d;
    end
  end

  assign locked      = locked_q;
  assign de          = de_q;
  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign frame_start = frame_start_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign err         = err_q;

endmodule
